// File: rtl/tbl_pkg.sv
// Shared types and constants for the multiport lookup table.
// The sweep value for each entry comes from identity_entry() so every block agrees on it.
package tbl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;
  localparam int NUM_RD_DEF = 2;

  // Entry value written by the init sweep. Callers truncate the result to DATA_W.
  function automatic logic [31:0] identity_entry(input logic [31:0] idx);
    return idx;
  endfunction

endpackage

// File: rtl/tbl_rd_chan.sv
// One read channel: range check, one-cycle response register and error flag.
// The table entry arrives already selected by the top level.
module tbl_rd_chan
  import tbl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_valid,
  input  logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] entry,
  output logic              out_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err
);

  logic fire;
  logic in_range;

  assign fire     = rd_valid & rd_ready;
  assign in_range = int'(rd_addr) < DEPTH;

  // Data holds its last value when no read is accepted; valid and err do not.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      rd_data   <= '0;
      rd_err    <= 1'b0;
    end else begin
      out_valid <= fire;
      rd_err    <= fire & ~in_range;
      if (fire) rd_data <= in_range ? entry : '0;
    end
  end

endmodule

// File: rtl/tbl_multiport.sv
// Writable lookup table with NUM_RD registered read channels and an identity init sweep.
// Storage, write path and the INIT/IDLE controller live here; read channels are sub-modules.
module tbl_multiport
  import tbl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_init_start,
  output logic                     io_busy,
  input  logic                     io_wr_valid,
  output logic                     io_wr_ready,
  input  logic [ADDR_W-1:0]        io_wr_addr,
  input  logic [DATA_W-1:0]        io_wr_data,
  output logic                     io_wr_err,
  input  logic [NUM_RD-1:0]        io_rd_valid,
  output logic [NUM_RD-1:0]        io_rd_ready,
  input  logic [NUM_RD*ADDR_W-1:0] io_rd_addr,
  output logic [NUM_RD-1:0]        io_rd_out_valid,
  output logic [NUM_RD*DATA_W-1:0] io_rd_data,
  output logic [NUM_RD-1:0]        io_rd_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state, state_next;
  logic [IDX_W-1:0] cnt, cnt_next;
  logic             idle;
  logic             last;
  logic             wr_fire;
  logic             wr_in_range;
  logic [DATA_W-1:0] mem [DEPTH];

  assign idle        = (state == IDLE);
  assign last        = (cnt == IDX_W'(DEPTH - 1));
  assign wr_fire     = io_wr_valid & idle;
  assign wr_in_range = int'(io_wr_addr) < DEPTH;

  assign io_busy     = ~idle;
  assign io_wr_ready = idle;
  assign io_rd_ready = {NUM_RD{idle}};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: defaults assigned first so no path through this block infers a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      INIT: begin
        cnt_next = last ? '0 : cnt + 1'b1;
        if (last) state_next = IDLE;
      end
      IDLE: begin
        if (io_init_start) state_next = INIT;
      end
      default: state_next = INIT;
    endcase
  end

  // NOTE: storage is deliberately not reset; the init sweep is what defines its contents.
  always_ff @(posedge clock) begin
    if (!idle) begin
      mem[cnt] <= DATA_W'(identity_entry(32'(cnt)));
    end else if (wr_fire && wr_in_range) begin
      mem[io_wr_addr[IDX_W-1:0]] <= io_wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) io_wr_err <= 1'b0;
    else        io_wr_err <= wr_fire & ~wr_in_range;
  end

  // Reads see mem before this edge's write, which gives read-before-write ordering.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = io_rd_addr[k*ADDR_W +: ADDR_W];

    tbl_rd_chan #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
    ) u_chan (
      .clock    (clock),
      .reset    (reset),
      .rd_valid (io_rd_valid[k]),
      .rd_ready (idle),
      .rd_addr  (addr),
      .entry    (mem[addr[IDX_W-1:0]]),
      .out_valid(io_rd_out_valid[k]),
      .rd_data  (io_rd_data[k*DATA_W +: DATA_W]),
      .rd_err   (io_rd_err[k])
    );
  end

endmodule

// File: tb/tb_tbl_multiport.sv
// Self-checking bench for tbl_multiport: default build scored against a table model,
// plus a DEPTH=200 build for range errors and a 12-bit, 4-channel build.
module tb_tbl_multiport;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        init_start;

  // default build
  logic        busy, wr_valid, wr_ready, wr_err;
  logic [7:0]  wr_addr, wr_data;
  logic [1:0]  rd_valid, rd_ready, rd_out_valid, rd_err;
  logic [15:0] rd_addr, rd_data;

  // DEPTH=200 build
  logic        s_busy, s_wr_valid, s_wr_ready, s_wr_err;
  logic [7:0]  s_wr_addr, s_wr_data;
  logic [1:0]  s_rd_valid, s_rd_ready, s_rd_out_valid, s_rd_err;
  logic [15:0] s_rd_addr, s_rd_data;

  // DATA_W=12, NUM_RD=4 build
  logic        w_busy, w_wr_valid, w_wr_ready, w_wr_err;
  logic [7:0]  w_wr_addr;
  logic [11:0] w_wr_data;
  logic [3:0]  w_rd_valid, w_rd_ready, w_rd_out_valid, w_rd_err;
  logic [31:0] w_rd_addr;
  logic [47:0] w_rd_data;

  tbl_multiport u_dut (
    .clock(clock), .reset(reset), .io_init_start(init_start), .io_busy(busy),
    .io_wr_valid(wr_valid), .io_wr_ready(wr_ready), .io_wr_addr(wr_addr),
    .io_wr_data(wr_data), .io_wr_err(wr_err),
    .io_rd_valid(rd_valid), .io_rd_ready(rd_ready), .io_rd_addr(rd_addr),
    .io_rd_out_valid(rd_out_valid), .io_rd_data(rd_data), .io_rd_err(rd_err)
  );

  tbl_multiport #(.DEPTH(200)) u_small (
    .clock(clock), .reset(reset), .io_init_start(init_start), .io_busy(s_busy),
    .io_wr_valid(s_wr_valid), .io_wr_ready(s_wr_ready), .io_wr_addr(s_wr_addr),
    .io_wr_data(s_wr_data), .io_wr_err(s_wr_err),
    .io_rd_valid(s_rd_valid), .io_rd_ready(s_rd_ready), .io_rd_addr(s_rd_addr),
    .io_rd_out_valid(s_rd_out_valid), .io_rd_data(s_rd_data), .io_rd_err(s_rd_err)
  );

  tbl_multiport #(.DATA_W(12), .NUM_RD(4)) u_wide (
    .clock(clock), .reset(reset), .io_init_start(init_start), .io_busy(w_busy),
    .io_wr_valid(w_wr_valid), .io_wr_ready(w_wr_ready), .io_wr_addr(w_wr_addr),
    .io_wr_data(w_wr_data), .io_wr_err(w_wr_err),
    .io_rd_valid(w_rd_valid), .io_rd_ready(w_rd_ready), .io_rd_addr(w_rd_addr),
    .io_rd_out_valid(w_rd_out_valid), .io_rd_data(w_rd_data), .io_rd_err(w_rd_err)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] model [256];
  bit         exp_idle = 1'b0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  task automatic model_identity();
    for (int i = 0; i < 256; i++) model[i] = 8'(i);
  endtask

  // One clock of traffic on the default build: expected responses are queued from the
  // model before the edge (read-before-write), then popped and compared after it.
  task automatic step();
    logic [7:0] exp;
    if (exp_idle) begin
      if (rd_valid[0]) q0.push_back(model[rd_addr[7:0]]);
      if (rd_valid[1]) q1.push_back(model[rd_addr[15:8]]);
      if (wr_valid) model[wr_addr] = wr_data;
    end
    @(posedge clock); #1;
    checks++;
    if (q0.size() > 0) begin
      exp = q0.pop_front();
      if (rd_out_valid[0] !== 1'b1 || rd_data[7:0] !== exp || rd_err[0] !== 1'b0) begin
        errors++;
        $display("FAIL rd_ch0: got valid=%b data=%h err=%b, want valid=1 data=%h err=0",
                 rd_out_valid[0], rd_data[7:0], rd_err[0], exp);
      end
    end else if (rd_out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL rd_ch0_idle: got valid=%b, want 0", rd_out_valid[0]);
    end
    checks++;
    if (q1.size() > 0) begin
      exp = q1.pop_front();
      if (rd_out_valid[1] !== 1'b1 || rd_data[15:8] !== exp || rd_err[1] !== 1'b0) begin
        errors++;
        $display("FAIL rd_ch1: got valid=%b data=%h err=%b, want valid=1 data=%h err=0",
                 rd_out_valid[1], rd_data[15:8], rd_err[1], exp);
      end
    end else if (rd_out_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL rd_ch1_idle: got valid=%b, want 0", rd_out_valid[1]);
    end
  endtask

  // Counts edges until busy drops (bounded); pulses init_start once at edge index kick.
  task automatic wait_busy(input string name, input int kick);
    int n   = 0;
    bit bad = 1'b0;
    while (busy === 1'b1 && n < 2000) begin
      init_start = (n == kick);
      @(posedge clock); #1;
      n++;
      if (busy === 1'b1 && (rd_ready !== 2'b00 || wr_ready !== 1'b0)) bad = 1'b1;
      if (rd_out_valid !== 2'b00) bad = 1'b1;
    end
    init_start = 1'b0;
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL %s_busy_len: got %0d cycles, want 256", name, n);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s_accept_while_busy: got ready/valid activity during sweep, want none", name);
    end
    checks++;
    if (rd_ready !== 2'b11 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_rise: got rd_ready=%b wr_ready=%b, want 11 1", name, rd_ready, wr_ready);
    end
  endtask

  task automatic test_reset();
    init_start = 0; wr_valid = 0; wr_addr = 0; wr_data = 0; rd_valid = 0; rd_addr = 0;
    s_wr_valid = 0; s_wr_addr = 0; s_wr_data = 0; s_rd_valid = 0; s_rd_addr = 0;
    w_wr_valid = 0; w_wr_addr = 0; w_wr_data = 0; w_rd_valid = 0; w_rd_addr = 0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy, wr_ready, wr_err, rd_ready, rd_out_valid, rd_err} !== 9'b1_0000_0000 ||
        rd_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_values: got busy=%b wr_ready=%b wr_err=%b rd_ready=%b ov=%b err=%b data=%h, want 1 0 0 00 00 00 0000",
               busy, wr_ready, wr_err, rd_ready, rd_out_valid, rd_err, rd_data);
    end
    rd_valid = 2'b11;
    rd_addr  = {8'h7F, 8'h00};
    reset    = 1'b1;
    wait_busy("init", -1);
    model_identity();
    exp_idle = 1'b1;
    step();
    rd_addr = {8'h80, 8'hFF};
    step();
    rd_addr = {8'hFF, 8'h7F};
    step();
    rd_valid = 2'b00;
    step();
  endtask

  task automatic test_rw_collision();
    wr_valid = 1; wr_addr = 8'h10; wr_data = 8'hA5;
    rd_valid = 2'b01; rd_addr = {8'h00, 8'h10};
    step();
    wr_valid = 0;
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_err_in_range: got %b, want 0", wr_err);
    end
    step();
    rd_valid = 2'b10; rd_addr = {8'h10, 8'h00};
    step();
    rd_valid = 2'b11; rd_addr = {8'h10, 8'h10};
    step();
    rd_valid = 2'b00;
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = 8'($urandom_range(0, 15));
      wr_data  = 8'($urandom);
      rd_valid = 2'($urandom_range(0, 3));
      rd_addr  = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
      step();
    end
    wr_valid = 0; rd_valid = 0;
    step();
  endtask

  task automatic test_out_of_range();
    s_wr_valid = 1; s_wr_addr = 8'hC8; s_wr_data = 8'h55;
    @(posedge clock); #1;
    s_wr_valid = 0;
    checks++;
    if (s_wr_err !== 1'b1) begin
      errors++;
      $display("FAIL wr_err_pulse: got %b, want 1", s_wr_err);
    end
    @(posedge clock); #1;
    checks++;
    if (s_wr_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_err_one_cycle: got %b, want 0", s_wr_err);
    end
    s_rd_valid = 2'b11; s_rd_addr = {8'hD0, 8'hC7};
    @(posedge clock); #1;
    s_rd_valid = 2'b00;
    checks++;
    if (s_rd_out_valid !== 2'b11 || s_rd_data !== 16'h00C7 || s_rd_err !== 2'b10) begin
      errors++;
      $display("FAIL oor_read: got valid=%b data=%h err=%b, want 11 00c7 10",
               s_rd_out_valid, s_rd_data, s_rd_err);
    end
  endtask

  task automatic test_init_restart();
    wr_valid = 1; wr_addr = 8'h05; wr_data = 8'h33;
    step();
    wr_valid = 0;
    rd_valid = 2'b01; rd_addr = {8'h00, 8'h05};
    step();
    rd_valid = 2'b00;
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    exp_idle = 1'b0;
    rd_valid = 2'b11;
    wait_busy("restart", 50);
    model_identity();
    exp_idle = 1'b1;
    rd_valid = 2'b01; rd_addr = {8'h00, 8'h05};
    step();
    rd_valid = 2'b00;
  endtask

  task automatic test_reset_mid_sweep();
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    exp_idle = 1'b0;
    repeat (99) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, wr_ready, wr_err, rd_ready, rd_out_valid, rd_err} !== 9'b1_0000_0000 ||
        rd_data !== 16'h0 || w_busy !== 1'b1 || w_rd_data !== 48'h0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b wr_ready=%b rd_ready=%b ov=%b data=%h w_busy=%b, want 1 0 00 00 0000 1",
               busy, wr_ready, rd_ready, rd_out_valid, rd_data, w_busy);
    end
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    wait_busy("reset_restart", -1);
    model_identity();
    exp_idle = 1'b1;
  endtask

  task automatic test_wide();
    w_rd_valid = 4'hF;
    w_rd_addr  = {8'hFF, 8'h03, 8'h02, 8'h01};
    @(posedge clock); #1;
    w_rd_valid = 4'h0;
    checks++;
    if (w_rd_out_valid !== 4'hF || w_rd_data !== {12'h0FF, 12'h003, 12'h002, 12'h001} ||
        w_rd_err !== 4'h0) begin
      errors++;
      $display("FAIL wide_read: got valid=%h data=%h err=%h, want f 0ff003002001 0",
               w_rd_out_valid, w_rd_data, w_rd_err);
    end
    @(posedge clock); #1;
    checks++;
    if (w_rd_out_valid !== 4'h0 || w_rd_data !== {12'h0FF, 12'h003, 12'h002, 12'h001}) begin
      errors++;
      $display("FAIL wide_hold: got valid=%h data=%h, want 0 0ff003002001",
               w_rd_out_valid, w_rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_rw_collision();
    test_back_to_back();
    test_out_of_range();
    test_init_restart();
    test_reset_mid_sweep();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
